// File: rtl/minmax_scan_ctrl.sv
// minmax_scan_ctrl: frame max/min finder sharing one magnitude comparator.
// Latency: the first sample takes 1 cycle and each later sample takes 3.
//   Done pulses 1 cycle after the last CMP_MIN, which is cycle 23 after Start for COUNT=8.
// Backpressure: DataReady is high only in ACCEPT. The source may stall indefinitely.
//
// Ports: Clk/Reset (sync, active-high); Start begins a frame while idle;
//        DataIn/DataValid/DataReady sample handshake; Busy = not idle;
//        Done one-cycle pulse; MaxOut/MinOut/MaxIndex/MinIndex frame results.
// Optional: define MINMAX_TIE_COUNT_EN to add MaxCount, the number of
//           occurrences of the frame maximum.

module mag_cmp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  output logic             Greater,
  output logic             Equal,
  output logic             Lesser
);
  assign Greater = (In1 > In2);
  assign Equal   = (In1 == In2);
  assign Lesser  = (In1 < In2);
endmodule

module minmax_scan_ctrl #(
  parameter  int WIDTH = 4,
  parameter  int COUNT = 8,
  localparam int IDXW  = $clog2(COUNT)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] DataIn,
  input  logic             DataValid,
  output logic             DataReady,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] MaxOut,
  output logic [WIDTH-1:0] MinOut,
`ifdef MINMAX_TIE_COUNT_EN
  output logic [IDXW:0]    MaxCount,
`endif
  output logic [IDXW-1:0]  MaxIndex,
  output logic [IDXW-1:0]  MinIndex
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACCEPT, S_CMP_MAX, S_CMP_MIN, S_DONE
  } state_t;

  localparam logic [IDXW:0] COUNT_L = (IDXW+1)'(COUNT);
  localparam logic [IDXW:0] ONE_L   = (IDXW+1)'(1);

  state_t           state_q, state_d;
  logic [IDXW:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sample_q, sample_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [IDXW-1:0]  max_idx_q, max_idx_d;
  logic [IDXW-1:0]  min_idx_q, min_idx_d;
  logic             ready_q, ready_d;
`ifdef MINMAX_TIE_COUNT_EN
  logic [IDXW:0]    maxcnt_q, maxcnt_d;
`endif

  logic             xfer;
  logic [IDXW:0]    cnt_inc;
  logic [WIDTH-1:0] cmp_b;
  logic             cmp_gt, cmp_eq, cmp_lt;

  assign xfer    = DataValid && ready_q;
  assign cnt_inc = cnt_q + ONE_L;

  // The single shared comparator sees only registered operands. Its second
  // operand switches between the running max and the running min by state.
  assign cmp_b = (state_q == S_CMP_MIN) ? min_q : max_q;

  mag_cmp #(.WIDTH(WIDTH)) u_cmp (
    .In1     (sample_q),
    .In2     (cmp_b),
    .Greater (cmp_gt),
    .Equal   (cmp_eq),
    .Lesser  (cmp_lt)
  );

`ifndef MINMAX_TIE_COUNT_EN
  logic unused_cmp_eq;
  assign unused_cmp_eq = cmp_eq;
`endif

  // State and datapath registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sample_q  <= '0;
      max_q     <= '0;
      min_q     <= '0;
      max_idx_q <= '0;
      min_idx_q <= '0;
      ready_q   <= 1'b0;
`ifdef MINMAX_TIE_COUNT_EN
      maxcnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sample_q  <= sample_d;
      max_q     <= max_d;
      min_q     <= min_d;
      max_idx_q <= max_idx_d;
      min_idx_q <= min_idx_d;
      ready_q   <= ready_d;
`ifdef MINMAX_TIE_COUNT_EN
      maxcnt_q  <= maxcnt_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (Start) state_d = S_ACCEPT;
      // COUNT >= 2, so the first sample always loops back to ACCEPT.
      S_ACCEPT:  if (xfer) state_d = (cnt_q == '0) ? S_ACCEPT : S_CMP_MAX;
      S_CMP_MAX: state_d = S_CMP_MIN;
      S_CMP_MIN: state_d = (cnt_inc == COUNT_L) ? S_DONE : S_ACCEPT;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    // DataReady is registered, so it is high for every cycle of ACCEPT.
    ready_d = (state_d == S_ACCEPT);
  end

  // Datapath updates
  always_comb begin
    cnt_d     = cnt_q;
    sample_d  = sample_q;
    max_d     = max_q;
    min_d     = min_q;
    max_idx_d = max_idx_q;
    min_idx_d = min_idx_q;
`ifdef MINMAX_TIE_COUNT_EN
    maxcnt_d  = maxcnt_q;
`endif
    case (state_q)
      S_IDLE: if (Start) cnt_d = '0;
      S_ACCEPT: begin
        if (xfer) begin
          sample_d = DataIn;
          if (cnt_q == '0) begin
            // The first sample seeds both extremes. Results of the previous
            // frame stay visible until this point.
            max_d     = DataIn;
            min_d     = DataIn;
            max_idx_d = '0;
            min_idx_d = '0;
            cnt_d     = ONE_L;
`ifdef MINMAX_TIE_COUNT_EN
            maxcnt_d  = ONE_L;
`endif
          end
        end
      end
      S_CMP_MAX: begin
        // The update uses strict greater-than, so a tie keeps the earlier index.
        if (cmp_gt) begin
          max_d     = sample_q;
          max_idx_d = cnt_q[IDXW-1:0];
`ifdef MINMAX_TIE_COUNT_EN
          maxcnt_d  = ONE_L;
        end else if (cmp_eq) begin
          maxcnt_d  = maxcnt_q + ONE_L;
`endif
        end
      end
      S_CMP_MIN: begin
        if (cmp_lt) begin
          min_d     = sample_q;
          min_idx_d = cnt_q[IDXW-1:0];
        end
        cnt_d = cnt_inc;
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    DataReady = ready_q;
    Busy      = (state_q != S_IDLE);
    Done      = (state_q == S_DONE);
    MaxOut    = max_q;
    MinOut    = min_q;
    MaxIndex  = max_idx_q;
    MinIndex  = min_idx_q;
`ifdef MINMAX_TIE_COUNT_EN
    MaxCount  = maxcnt_q;
`endif
  end

endmodule

// File: tb/tb_minmax_scan_ctrl.sv
// Bench for minmax_scan_ctrl with two instances, one at COUNT=4 and one at COUNT=8.
// Directed frames plus $urandom frames, with results checked against a
// frame-level model (max/min/first index/occurrence count over the sample list).

module tb_minmax_scan_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   ncmp = 0;
  int   nfail = 0;
  int   sel = 0;  // 0: COUNT=4 instance, 1: COUNT=8 instance

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       st4 = 1'b0, dv4 = 1'b0, rdy4, busy4, done4;
  logic [3:0] di4 = '0, mx4, mn4;
  logic [1:0] mxi4, mni4;
  logic       st8 = 1'b0, dv8 = 1'b0, rdy8, busy8, done8;
  logic [3:0] di8 = '0, mx8, mn8;
  logic [2:0] mxi8, mni8;
`ifdef MINMAX_TIE_COUNT_EN
  logic [2:0] mc4;
  logic [3:0] mc8;
`endif

  minmax_scan_ctrl #(.WIDTH(4), .COUNT(4)) u4 (
    .Clk(clk), .Reset(rst), .Start(st4), .DataIn(di4), .DataValid(dv4),
    .DataReady(rdy4), .Busy(busy4), .Done(done4), .MaxOut(mx4), .MinOut(mn4),
`ifdef MINMAX_TIE_COUNT_EN
    .MaxCount(mc4),
`endif
    .MaxIndex(mxi4), .MinIndex(mni4)
  );

  minmax_scan_ctrl #(.WIDTH(4), .COUNT(8)) u8 (
    .Clk(clk), .Reset(rst), .Start(st8), .DataIn(di8), .DataValid(dv8),
    .DataReady(rdy8), .Busy(busy8), .Done(done8), .MaxOut(mx8), .MinOut(mn8),
`ifdef MINMAX_TIE_COUNT_EN
    .MaxCount(mc8),
`endif
    .MaxIndex(mxi8), .MinIndex(mni8)
  );

  logic       o_rdy, o_busy, o_done;
  logic [3:0] o_mx, o_mn;
  logic [2:0] o_mxi, o_mni;
  always_comb begin
    o_rdy  = sel != 0 ? rdy8  : rdy4;
    o_busy = sel != 0 ? busy8 : busy4;
    o_done = sel != 0 ? done8 : done4;
    o_mx   = sel != 0 ? mx8   : mx4;
    o_mn   = sel != 0 ? mn8   : mn4;
    o_mxi  = sel != 0 ? mxi8  : {1'b0, mxi4};
    o_mni  = sel != 0 ? mni8  : {1'b0, mni4};
  end
`ifdef MINMAX_TIE_COUNT_EN
  logic [3:0] o_mc;
  always_comb o_mc = sel != 0 ? mc8 : {1'b0, mc4};
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic s, input logic v, input logic [3:0] d);
    if (sel != 0) begin st8 = s; dv8 = v; di8 = d; end
    else begin st4 = s; dv4 = v; di4 = d; end
  endtask

  // Drives one frame on the selected instance and checks latency and results.
  task automatic run_frame(input int n, input logic [3:0] smp [8], input int stall,
                           input int mid_start, input string tag);
    int k = 0, stall_left = stall, c0, cdone = -1, ecnt = 0;
    int eimax = 0, eimin = 0;
    logic [3:0] emax, emin;
    emax = smp[0];
    emin = smp[0];
    for (int i = 1; i < n; i++) begin
      if (smp[i] > emax) begin emax = smp[i]; eimax = i; end
      if (smp[i] < emin) begin emin = smp[i]; eimin = i; end
    end
    for (int i = 0; i < n; i++) if (smp[i] == emax) ecnt++;

    @(negedge clk);
    set_in(1'b1, 1'b0, 4'd0);
    c0 = cyc;
    for (int it = 0; it < 400; it++) begin
      @(negedge clk);
      if (o_done) begin cdone = cyc; break; end
      if (k < n) begin
        if (o_rdy && stall_left > 0) begin
          set_in(it == mid_start, 1'b0, smp[k]);
          stall_left--;
        end else begin
          set_in(it == mid_start, 1'b1, smp[k]);
          if (o_rdy) begin k++; stall_left = stall; end
        end
      end else begin
        set_in(it == mid_start, 1'b0, 4'd0);
      end
    end
    chk({tag, " done_latency"}, cdone - c0, 2 + 3 * (n - 1) + n * stall);
    chk({tag, " max"}, o_mx, emax);
    chk({tag, " max_idx"}, o_mxi, eimax);
    chk({tag, " min"}, o_mn, emin);
    chk({tag, " min_idx"}, o_mni, eimin);
`ifdef MINMAX_TIE_COUNT_EN
    chk({tag, " max_count"}, o_mc, ecnt);
`endif
    set_in(1'b0, 1'b0, 4'd0);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, {o_done, o_busy}, 2'b00);
    chk({tag, " max_held"}, o_mx, emax);
  endtask

  initial begin
    logic [3:0] smp [8];
    logic       saw_done;

    // Reset held 2 cycles, then idle behaviour
    repeat (2) @(posedge clk);
    @(negedge clk);
    sel = 0;
    chk("rst4 ctrl", {o_rdy, o_busy, o_done}, 3'b000);
    chk("rst4 results", {o_mx, o_mn, o_mxi, o_mni}, 14'd0);
    sel = 1;
    chk("rst8 ctrl", {o_rdy, o_busy, o_done}, 3'b000);
    chk("rst8 results", {o_mx, o_mn, o_mxi, o_mni}, 14'd0);
`ifdef MINMAX_TIE_COUNT_EN
    chk("rst8 max_count", o_mc, 0);
`endif
    rst = 1'b0;
    sel = 0;
    @(negedge clk);
    set_in(1'b0, 1'b1, 4'd7);
    @(negedge clk);
    chk("idle ready", o_rdy, 1'b0);
    set_in(1'b0, 1'b0, 4'd0);
    @(negedge clk);
    chk("idle no capture", {o_busy, o_mx, o_mn}, 9'd0);

    // COUNT=4 directed frames
    smp = '{4'd5, 4'd9, 4'd2, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0};
    run_frame(4, smp, 0, -1, "f5929");
    smp = '{4'd15, 4'd0, 4'd0, 4'd15, 4'd0, 4'd0, 4'd0, 4'd0};
    run_frame(4, smp, 0, -1, "fbound");
    smp = '{4'd5, 4'd9, 4'd2, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0};
    run_frame(4, smp, 3, -1, "fstall");

    // Reset asserted in CMP_MIN of the second sample
    @(negedge clk);
    set_in(1'b1, 1'b0, 4'd0);
    @(negedge clk);
    set_in(1'b0, 1'b1, 4'd5);
    @(negedge clk);
    set_in(1'b0, 1'b1, 4'd9);
    @(negedge clk);
    @(negedge clk);
    chk("midrst cmp_min state", {o_busy, o_rdy}, 2'b10);
    chk("midrst max updated", o_mx, 9);
    rst = 1'b1;
    set_in(1'b0, 1'b0, 4'd0);
    @(negedge clk);
    chk("midrst ctrl", {o_rdy, o_busy, o_done}, 3'b000);
    chk("midrst results", {o_mx, o_mn, o_mxi, o_mni}, 14'd0);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      saw_done = saw_done | o_done | o_busy;
    end
    chk("midrst no done", saw_done, 1'b0);
    smp = '{4'd3, 4'd3, 4'd3, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0};
    run_frame(4, smp, 0, -1, "fties");

    // COUNT=8 throughput with a Start pulse in the middle of the frame
    sel = 1;
    smp = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    run_frame(8, smp, 0, 5, "fdesc8");

    // Random frames; a narrow value range forces ties.
    for (int f = 0; f < 8; f++) begin
      int hi;
      sel = (f >= 6) ? 1 : 0;
      hi = (f % 2 == 0) ? 15 : 3;
      for (int i = 0; i < 8; i++) smp[i] = 4'($urandom_range(0, hi));
      run_frame(sel != 0 ? 8 : 4, smp, int'($urandom_range(0, 2)), -1, "frand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/minmax_scan_ctrl.md
Name: minmax_scan_ctrl

Overview:
- Sequencer that time-shares one instance of the team's 4-bit magnitude comparator to find the maximum and minimum of a frame of COUNT samples streamed in over a valid/ready handshake.
- Per sample, the comparator is used twice: sample vs running max, then sample vs running min.
- Sits between a sample source and downstream logic that consumes the frame extremes on Done.

Parameters:
- WIDTH, 4, sample width; must match the comparator input width.
- COUNT, 8, samples per frame; must be at least 2.
- IDXW, $clog2(COUNT), width of the index outputs; derived, not overridden.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  begins a frame; sampled only in IDLE.
- DataIn  input  WIDTH  sample value.
- DataValid  input  1  DataIn is valid.
- DataReady  output  1  controller accepts a sample this cycle.
- Busy  output  1  high in every state except IDLE.
- Done  output  1  one-cycle pulse when frame results are final.
- MaxOut  output  WIDTH  frame maximum.
- MinOut  output  WIDTH  frame minimum.
- MaxIndex  output  IDXW  position within the frame (0-based) of the first occurrence of the maximum.
- MinIndex  output  IDXW  position within the frame (0-based) of the first occurrence of the minimum.

Behaviour:
- Reset: state=IDLE, sample counter=0, DataReady=0, Busy=0, Done=0, MaxOut=0, MinOut=0, MaxIndex=0, MinIndex=0. Reset mid-frame abandons the frame; no Done is produced.
- States are IDLE, ACCEPT, CMP_MAX, CMP_MIN, DONE.
- IDLE:
  - Start=1 -> ACCEPT next cycle; sample counter cleared.
  - Results from the previous frame are held.
- ACCEPT:
  - DataReady=1 (registered output, high for the whole state).
  - Transfer occurs when DataValid && DataReady; DataIn is latched into the Sample register.
  - No transfer -> remain in ACCEPT, nothing changes.
  - First sample of the frame (counter=0): MaxOut=MinOut=DataIn, both indices=0, counter=1. Go to ACCEPT, or to DONE if COUNT were 1; COUNT=1 is disallowed.
  - Any later sample -> CMP_MAX.
- CMP_MAX:
  - Comparator In1=Sample, In2=MaxOut.
  - Greater=1 -> MaxOut=Sample, MaxIndex=counter.
  - Equal or Lesser -> no update, so ties keep the earlier index.
  - Next state is CMP_MIN.
- CMP_MIN:
  - Comparator In1=Sample, In2=MinOut.
  - Lesser=1 -> MinOut=Sample, MinIndex=counter.
  - counter increments.
  - If the incremented counter equals COUNT -> DONE, else -> ACCEPT.
- DONE: Done=1 for exactly one cycle, then IDLE. Outputs hold until the first sample of the next frame.
- Throughput and latency:
  - First sample: 1 cycle. Each later sample: 3 cycles (ACCEPT, CMP_MAX, CMP_MIN), assuming DataValid is held high.
  - Done is asserted 1 cycle after the final CMP_MIN.
  - COUNT=8 with continuous valid: Start at cycle 0, Done at cycle 1+1+7*3 = 23.
- Comparator inputs are driven from registers only. The comparator is combinational; its outputs are consumed in the same cycle.
- Start while Busy is ignored. DataValid outside ACCEPT is ignored; DataReady=0 there.
- Counter arithmetic is unsigned IDXW+1 bits, so reaching COUNT never wraps.
- Values 0 and 2^WIDTH-1 are legal samples with no special casing.

Optional Feature:
- Macro: MINMAX_TIE_COUNT_EN.
- Defined:
  - Adds output MaxCount, width IDXW+1, reset to 0.
  - First sample sets MaxCount=1.
  - In CMP_MAX: Greater sets MaxCount=1; Equal increments MaxCount; Lesser leaves it unchanged.
  - Valid when Done is asserted; held like the other results.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: hold Reset 2 cycles -> all outputs 0, Busy=0; pulse DataValid with DataIn=7 in IDLE -> DataReady stays 0 and no state change.
- COUNT=4 (all tests at this value except the throughput test), samples 5,9,2,9, DataValid continuously high -> Done at cycle 11 after Start; MaxOut=9, MaxIndex=1, MinOut=2, MinIndex=2; with MINMAX_TIE_COUNT_EN, MaxCount=2.
- Boundary values 15,0,0,15 -> MaxOut=15, MaxIndex=0, MinOut=0, MinIndex=1; MaxCount=2 when enabled.
- Source stalls: DataValid low for 3 cycles in every ACCEPT -> DataReady stays high with no capture; final results identical to the continuous case; Done 12 cycles later than the continuous case.
- Reset mid-frame, asserted in CMP_MIN of the 2nd sample -> next cycle IDLE, outputs 0, no Done. Then Start with 3,3,3,3 -> Max=Min=3, both indices 0.
- COUNT=8 default, descending 7..0 -> Done at cycle 23 after Start; MaxOut=7, MaxIndex=0, MinOut=0, MinIndex=7. A Start pulsed mid-frame is ignored.
